// File: rtl/node_memory_access_if.sv
// ---------------------------------------------------------------------------
// node_memory_access_if
//   Bundles the three buses of the node memory responder:
//     asi_request_*  : 128-bit request stream into the responder
//     aso_result_*   : 96-bit result stream (plus 2-bit channel) out
//     avs_config_*   : small memory-mapped config slave (HPS side)
//   slave  : responder view (node_memory_access)
//   master : requester / host view
// ---------------------------------------------------------------------------
interface node_memory_access_if;
  logic [127:0] asi_request_data;
  logic         asi_request_valid;
  logic         asi_request_ready;

  logic [95:0]  aso_result_data;
  logic [1:0]   aso_result_channel;
  logic         aso_result_valid;
  logic         aso_result_ready;

  logic [15:0]  avs_config_address;
  logic         avs_config_write;
  logic [31:0]  avs_config_writedata;
  logic         avs_config_read;
  logic [31:0]  avs_config_readdata;
  logic         avs_config_readdatavalid;
  logic         avs_config_waitrequest;

  modport slave (
    input  asi_request_data, asi_request_valid,
    output asi_request_ready,
    output aso_result_data, aso_result_channel, aso_result_valid,
    input  aso_result_ready,
    input  avs_config_address, avs_config_write, avs_config_writedata,
    input  avs_config_read,
    output avs_config_readdata, avs_config_readdatavalid,
    output avs_config_waitrequest
  );

  modport master (
    output asi_request_data, asi_request_valid,
    input  asi_request_ready,
    input  aso_result_data, aso_result_channel, aso_result_valid,
    output aso_result_ready,
    output avs_config_address, avs_config_write, avs_config_writedata,
    output avs_config_read,
    input  avs_config_readdata, avs_config_readdatavalid,
    input  avs_config_waitrequest
  );
endinterface

// File: rtl/node_memory_access.sv
// ---------------------------------------------------------------------------
// node_memory_access
//   Responder for the node memory request/result protocol. Serves one request
//   at a time from on-chip node RAM (fetch / insert / write-next) and owns the
//   node allocator (freePtr), which the host can read and reset through the
//   config slave.
//
//   Ports:
//     clk    : clock
//     reset  : asynchronous, active-high reset
//     bus    : node_memory_access_if.slave (request, result, config buses)
//     error  : sticky; allocator full on insert, or reserved request type
//
//   State | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; applies a pending config clear first
//   RD    | node RAM read data registered (fetch result / RMW source)
//   RMW_WR| write node back with the new next field
//   RESP  | result held on aso_result_* until aso_result_ready
// ---------------------------------------------------------------------------
module node_memory_access #(
  parameter int NODE_ADDR_BITS = 14,
  parameter int VAR_BITS       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  node_memory_access_if.slave   bus,
  output logic                  error
);

  localparam int DEPTH = 1 << NODE_ADDR_BITS;

  localparam logic [1:0] T_FETCH  = 2'b00;
  localparam logic [1:0] T_INSERT = 2'b01;
  localparam logic [1:0] T_WNN    = 2'b10;

  localparam logic [NODE_ADDR_BITS:0] FP_ONE = {{NODE_ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t                    state_q;
  logic [1:0]                op_q;
  logic [1:0]                src_q;
  logic [NODE_ADDR_BITS-1:0] addr_q;
  logic [29:0]               next_q;
  logic [NODE_ADDR_BITS:0]   fp_q;
  logic                      err_q;
  logic                      clr_pend_q;
  logic                      res_valid_q;
  logic [95:0]               res_data_q;
  logic [1:0]                res_chan_q;
  logic                      rdv_q;
  logic [31:0]               rdata_q;

  logic [89:0]               node_mem [DEPTH];
  logic [VAR_BITS-1:0]       var_mem  [DEPTH];
  logic [89:0]               ram_q;
  logic [VAR_BITS-1:0]       var_q;

  // Request field decode
  logic [127:0]              req;
  logic [1:0]                req_type;
  logic [1:0]                req_src;
  logic [NODE_ADDR_BITS-1:0] req_addr;
  logic [VAR_BITS-1:0]       req_var;
  logic [89:0]               req_node;
  logic [29:0]               req_next;

  assign req      = bus.asi_request_data;
  assign req_type = req[1:0];
  assign req_src  = req[3:2];
  assign req_addr = req[5 +: NODE_ADDR_BITS];
  assign req_var  = req[4 +: VAR_BITS];
  assign req_node = req[34 +: 90];
  assign req_next = req[34 +: 30];

  logic ready;
  logic accept;
  logic fp_full;
  logic cfg_clr;

  assign ready   = (state_q == S_IDLE) && !clr_pend_q;
  assign accept  = ready && bus.asi_request_valid;
  assign fp_full = fp_q[NODE_ADDR_BITS];
  assign cfg_clr = bus.avs_config_write && (bus.avs_config_address == 16'h0000);

  // RAM write port: insert writes at accept, RMW writes in RMW_WR; the two
  // can never coincide since accepts only happen in IDLE.
  logic                      mem_we_d;
  logic                      var_we_d;
  logic [NODE_ADDR_BITS-1:0] mem_waddr_d;
  logic [89:0]               mem_wdata_d;

  always_comb begin
    mem_we_d    = 1'b0;
    var_we_d    = 1'b0;
    mem_waddr_d = req_addr;
    mem_wdata_d = req_node;
    if (accept && (req_type == T_INSERT) && !fp_full) begin
      mem_we_d    = 1'b1;
      var_we_d    = 1'b1;
      mem_waddr_d = fp_q[NODE_ADDR_BITS-1:0];
    end else if (state_q == S_RMW_WR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = addr_q;
      mem_wdata_d = {ram_q[89:30], next_q};
    end
  end

  // Node/var RAMs: contents survive reset, read is registered on accept.
  always_ff @(posedge clk) begin
    if (mem_we_d) node_mem[mem_waddr_d] <= mem_wdata_d;
    if (var_we_d) var_mem[mem_waddr_d]  <= req_var;
    if (accept) begin
      ram_q <= node_mem[req_addr];
      var_q <= var_mem[req_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= T_FETCH;
      src_q       <= 2'b00;
      addr_q      <= '0;
      next_q      <= '0;
      fp_q        <= FP_ONE;
      err_q       <= 1'b0;
      clr_pend_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_chan_q  <= 2'b00;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rdv_q   <= bus.avs_config_read;
      rdata_q <= (bus.avs_config_read && (bus.avs_config_address == 16'h0000))
                 ? 32'(fp_q) : 32'd0;

      // A clear arriving while busy waits for the next IDLE cycle.
      if (cfg_clr && (state_q != S_IDLE)) clr_pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (clr_pend_q || (cfg_clr && !accept)) begin
            fp_q       <= FP_ONE;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
          end else if (accept) begin
            // Clear colliding with an accept is deferred past this request.
            if (cfg_clr) clr_pend_q <= 1'b1;
            op_q   <= req_type;
            src_q  <= req_src;
            addr_q <= req_addr;
            next_q <= req_next;
            case (req_type)
              T_FETCH, T_WNN: state_q <= S_RD;
              T_INSERT: begin
                res_valid_q <= 1'b1;
                res_chan_q  <= req_src;
                state_q     <= S_RESP;
                if (fp_full) begin
                  res_data_q <= '0;
                  err_q      <= 1'b1;
                end else begin
                  res_data_q <= {{(96 - NODE_ADDR_BITS - 2){1'b0}}, fp_q, 1'b0};
                  fp_q       <= fp_q + FP_ONE;
                end
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_RD: begin
          if (op_q == T_FETCH) begin
            res_data_q  <= {6'b0, ram_q};
            res_chan_q  <= src_q;
            res_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            state_q <= S_RMW_WR;
          end
        end
        S_RMW_WR: state_q <= S_IDLE;
        S_RESP: begin
          if (bus.aso_result_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.asi_request_ready        = ready;
  assign bus.aso_result_data          = res_data_q;
  assign bus.aso_result_channel       = res_chan_q;
  assign bus.aso_result_valid         = res_valid_q;
  assign bus.avs_config_readdata      = rdata_q;
  assign bus.avs_config_readdatavalid = rdv_q;
  assign bus.avs_config_waitrequest   = 1'b0;
  assign error                        = err_q;

  // Request bits outside the decoded fields, the write data of the clear
  // register and the var RAM read port have no consumer here.
  logic unused_bits;
  assign unused_bits = &{1'b0, req, var_q, bus.avs_config_writedata};

endmodule

// File: tb/tb_node_memory_access.sv
module tb_node_memory_access;
  localparam int NAB   = 2;
  localparam int DEPTH = 1 << NAB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic error;

  node_memory_access_if bus();

  node_memory_access #(.NODE_ADDR_BITS(NAB), .VAR_BITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .error (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain node array, allocator count and sticky error.
  logic [89:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_fp;
  bit          m_err;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_req(input logic [1:0] t, input logic [1:0] src,
                                          input logic [29:0] idx, input logic [93:0] d);
    return {d, idx, src, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) for it to be taken; returns one
  // cycle after the accept edge, i.e. in cycle N+1.
  task automatic send(input logic [127:0] r);
    int n = 0;
    bus.asi_request_data  = r;
    bus.asi_request_valid = 1'b1;
    while (bus.asi_request_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("accept_timeout", 96'(bus.asi_request_ready), 96'd1);
    tick();
    bus.asi_request_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [95:0] exp,
                            input logic [1:0] ch, input int hold);
    for (int i = 0; i <= hold; i++) begin
      chk({tag, "_valid"}, 96'(bus.aso_result_valid), 96'd1);
      chk({tag, "_data"}, bus.aso_result_data, exp);
      chk({tag, "_chan"}, 96'(bus.aso_result_channel), 96'(ch));
      chk({tag, "_busy"}, 96'(bus.asi_request_ready), 96'd0);
      if (i < hold) tick();
    end
    bus.aso_result_ready = 1'b1;
    tick();
    bus.aso_result_ready = 1'b0;
    chk({tag, "_valid_drop"}, 96'(bus.aso_result_valid), 96'd0);
    chk({tag, "_ready_back"}, 96'(bus.asi_request_ready), 96'd1);
  endtask

  task automatic do_insert(input logic [1:0] src, input logic [9:0] v,
                           input logic [89:0] node, input int hold);
    logic [95:0] exp;
    if (m_fp == DEPTH) begin
      exp   = '0;
      m_err = 1'b1;
    end else begin
      exp         = 96'(m_fp * 2);
      m_mem[m_fp] = node;
      m_wr[m_fp]  = 1'b1;
      m_fp++;
    end
    send(mk_req(2'b01, src, 30'(v), {4'b0, node}));
    get_result("insert", exp, src, hold);
    chk("insert_error", 96'(error), 96'(m_err));
  endtask

  task automatic do_fetch(input logic [1:0] src, input logic [NAB-1:0] a,
                          input logic neg, input int hold);
    logic [95:0] exp;
    exp = {6'b0, m_mem[a]};
    send(mk_req(2'b00, src, {27'b0, a, neg}, 94'd0));
    chk("fetch_lat1_valid", 96'(bus.aso_result_valid), 96'd0);
    tick();
    get_result("fetch", exp, src, hold);
  endtask

  task automatic do_wnn(input logic [1:0] src, input logic [NAB-1:0] a,
                        input logic neg, input logic [29:0] nx);
    m_mem[a][29:0] = nx;
    send(mk_req(2'b10, src, {27'b0, a, neg}, {64'b0, nx}));
    chk("wnn_n1_ready", 96'(bus.asi_request_ready), 96'd0);
    chk("wnn_n1_valid", 96'(bus.aso_result_valid), 96'd0);
    tick();
    chk("wnn_n2_ready", 96'(bus.asi_request_ready), 96'd0);
    chk("wnn_n2_valid", 96'(bus.aso_result_valid), 96'd0);
    tick();
    chk("wnn_n3_ready", 96'(bus.asi_request_ready), 96'd1);
    chk("wnn_n3_valid", 96'(bus.aso_result_valid), 96'd0);
  endtask

  task automatic cfg_read(input logic [15:0] a);
    logic [31:0] exp;
    exp = (a == 16'h0000) ? 32'(m_fp) : 32'd0;
    bus.avs_config_address = a;
    bus.avs_config_read    = 1'b1;
    tick();
    bus.avs_config_read    = 1'b0;
    chk("cfg_rdvalid", 96'(bus.avs_config_readdatavalid), 96'd1);
    chk("cfg_rdata", 96'(bus.avs_config_readdata), 96'(exp));
    tick();
    chk("cfg_rdvalid_pulse", 96'(bus.avs_config_readdatavalid), 96'd0);
  endtask

  task automatic cfg_clear();
    bus.avs_config_address = 16'h0000;
    bus.avs_config_write   = 1'b1;
    bus.avs_config_writedata = $urandom;
    tick();
    bus.avs_config_write   = 1'b0;
    m_fp  = 1;
    m_err = 1'b0;
    chk("clear_error", 96'(error), 96'd0);
  endtask

  task automatic do_reserved();
    send(mk_req(2'b11, 2'($urandom_range(0, 3)), 30'($urandom), 94'd0));
    m_err = 1'b1;
    chk("rsvd_valid", 96'(bus.aso_result_valid), 96'd0);
    chk("rsvd_error", 96'(error), 96'd1);
    chk("rsvd_ready", 96'(bus.asi_request_ready), 96'd1);
    tick();
    chk("rsvd_valid2", 96'(bus.aso_result_valid), 96'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [89:0] node;
    logic [NAB-1:0] a;
    int r;

    bus.asi_request_data     = '0;
    bus.asi_request_valid    = 1'b0;
    bus.aso_result_ready     = 1'b0;
    bus.avs_config_address   = '0;
    bus.avs_config_write     = 1'b0;
    bus.avs_config_writedata = '0;
    bus.avs_config_read      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_wr[i]  = 1'b0;
    end
    m_fp  = 1;
    m_err = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_req_ready", 96'(bus.asi_request_ready), 96'd1);
    chk("rst_res_valid", 96'(bus.aso_result_valid), 96'd0);
    chk("rst_res_data", bus.aso_result_data, 96'd0);
    chk("rst_res_chan", 96'(bus.aso_result_channel), 96'd0);
    chk("rst_error", 96'(error), 96'd0);
    chk("rst_rdvalid", 96'(bus.avs_config_readdatavalid), 96'd0);
    chk("rst_waitreq", 96'(bus.avs_config_waitrequest), 96'd0);

    // Insert var 5, then 0x10, else 0x20, next 0 -> index 0x2 on channel 1
    node = (90'h20 << 60) | (90'h10 << 30);
    do_insert(2'd1, 10'd5, node, 0);
    cfg_read(16'h0000);
    cfg_read(16'h0004);

    do_fetch(2'd2, 2'd1, 1'b0, 0);

    // Write-next through the negated index 0x3, then re-fetch 0x2
    do_wnn(2'd0, 2'd1, 1'b1, 30'h4);
    do_fetch(2'd2, 2'd1, 1'b0, 0);

    // Result held for 5 cycles of back-pressure
    do_fetch(2'd3, 2'd1, 1'b0, 5);

    // Allocator exhaustion on a 4-entry RAM
    cfg_clear();
    do_insert(2'd0, 10'd1, 90'h111, 0);
    do_insert(2'd1, 10'd2, 90'h222, 1);
    do_insert(2'd2, 10'd3, 90'h333, 0);
    do_insert(2'd3, 10'd4, 90'h444, 2);
    chk("full_error", 96'(error), 96'd1);
    cfg_read(16'h0000);
    cfg_clear();
    cfg_read(16'h0000);

    do_reserved();
    cfg_clear();

    // Randomised mix against the reference model
    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 10));
      a = NAB'($urandom_range(1, DEPTH - 1));
      node = 90'({$urandom, $urandom, $urandom});
      if (r <= 2 || ((r <= 7) && !m_wr[a])) begin
        do_insert(2'($urandom_range(0, 3)), 10'($urandom), node,
                  int'($urandom_range(0, 3)));
      end else if (r <= 5) begin
        do_fetch(2'($urandom_range(0, 3)), a, 1'($urandom), int'($urandom_range(0, 3)));
      end else if (r <= 7) begin
        do_wnn(2'($urandom_range(0, 3)), a, 1'($urandom), 30'($urandom));
      end else if (r == 8) begin
        cfg_read(($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535)));
      end else if (r == 9) begin
        cfg_clear();
      end else begin
        do_reserved();
      end
    end

    // Reset while a fetch sits in RD: no result may appear
    a = 2'd1;
    if (!m_wr[a]) do_insert(2'd0, 10'd0, 90'h55, 0);
    send(mk_req(2'b00, 2'd1, {27'b0, a, 1'b0}, 94'd0));
    reset = 1'b1;
    #1;
    chk("rstmid_valid", 96'(bus.aso_result_valid), 96'd0);
    tick();
    tick();
    #2;
    reset = 1'b0;
    m_fp  = 1;
    m_err = 1'b0;
    tick();
    chk("rstmid_ready", 96'(bus.asi_request_ready), 96'd1);
    chk("rstmid_error", 96'(error), 96'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_result", 96'(bus.aso_result_valid), 96'd0);
      tick();
    end
    cfg_read(16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
